// File: rtl/noc_pkg.sv
// Shared types for the NoC output-port controller: flit type encoding,
// flit layout constants and the port-controller state encoding.
package noc_pkg;

    localparam int FLIT_W        = 34;
    localparam int FLIT_TYPE_MSB = FLIT_W - 1;
    localparam int FLIT_TYPE_LSB = FLIT_W - 2;

    typedef enum logic [1:0] {
        BODY      = 2'b00,
        HEAD      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } port_state_t;

    function automatic logic is_head(input flit_type_t t);
        return (t == HEAD) || (t == HEAD_TAIL);
    endfunction

endpackage

// File: rtl/noc_output_port_ctrl_if.sv
// Signal bundle between one router output-port controller, its input
// sources, the external round-robin arbiter and the link.
interface noc_output_port_ctrl_if #(
    parameter int N_IN   = 2,
    parameter int FLIT_W = 34
);
    logic [N_IN-1:0]        in_valid_i;
    logic [N_IN*FLIT_W-1:0] in_flit_i;
    logic [N_IN-1:0]        in_ready_o;
    logic [N_IN-1:0]        arb_req_o;
    logic [N_IN-1:0]        arb_grant_i;
    logic                   arb_update_o;
    logic                   out_valid_o;
    logic [FLIT_W-1:0]      out_flit_o;
    logic                   out_ready_i;
    logic                   busy_o;
    logic                   err_o;

    modport slave (
        input  in_valid_i, in_flit_i, arb_grant_i, out_ready_i,
        output in_ready_o, arb_req_o, arb_update_o, out_valid_o, out_flit_o,
        busy_o, err_o
    );

    modport master (
        output in_valid_i, in_flit_i, arb_grant_i, out_ready_i,
        input  in_ready_o, arb_req_o, arb_update_o, out_valid_o, out_flit_o,
        busy_o, err_o
    );

endinterface

// File: rtl/noc_flit_fifo.sv
// Small registered flit FIFO feeding the link; head entry is read straight
// out of storage so nothing accepted this cycle is visible before the edge.
module noc_flit_fifo #(
    parameter int FLIT_W    = 34,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              push,
    input  logic [FLIT_W-1:0] push_flit,
    input  logic              pop,
    output logic [FLIT_W-1:0] head_flit,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [FLIT_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == CNT_W'(BUF_DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_flit = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_flit;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_output_port_ctrl.sv
// Output-port controller: requests the arbiter for head flits, locks the
// port to the granted input for a whole packet and queues flits to the link.
//
//   state  | meaning
//   IDLE   | no packet owns the port; head flits request the arbiter
//   LOCKED | port owned by input 'owner' until its TAIL flit is accepted
module noc_output_port_ctrl #(
    parameter int N_IN      = 2,
    parameter int FLIT_W    = 34,
    parameter int BUF_DEPTH = 2
) (
    input logic                   clk,
    input logic                   arst_n,
    noc_output_port_ctrl_if.slave bus
);

    import noc_pkg::*;

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    port_state_t       state;
    logic [IDX_W-1:0]  owner;
    logic              err;

    logic [N_IN-1:0]   req;
    logic [N_IN-1:0]   ready;
    logic              update;
    logic              push;
    logic [FLIT_W-1:0] push_flit;
    flit_type_t        push_type;
    logic              accept_idle;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_multi;
    logic              fifo_full;
    logic              fifo_empty;

    function automatic flit_type_t type_of(input logic [N_IN*FLIT_W-1:0] flits, input int k);
        return flit_type_t'(flits[k*FLIT_W + FLIT_TYPE_LSB +: (FLIT_TYPE_MSB - FLIT_TYPE_LSB + 1)]);
    endfunction

    assign grant_multi = (bus.arb_grant_i & (bus.arb_grant_i - N_IN'(1))) != '0;

    always_comb begin
        req         = '0;
        ready       = '0;
        update      = 1'b0;
        push        = 1'b0;
        push_flit   = '0;
        push_type   = BODY;
        accept_idle = 1'b0;
        grant_idx   = '0;
        case (state)
            IDLE: begin
                for (int k = 0; k < N_IN; k++) begin
                    req[k] = bus.in_valid_i[k] & is_head(type_of(bus.in_flit_i, k)) & ~fifo_full;
                    if (!grant_multi && bus.arb_grant_i[k] && req[k]) begin
                        accept_idle = 1'b1;
                        grant_idx   = IDX_W'(k);
                    end
                end
                if (accept_idle) begin
                    ready[grant_idx] = 1'b1;
                    update           = 1'b1;
                    push             = 1'b1;
                    push_flit        = bus.in_flit_i[int'(grant_idx)*FLIT_W +: FLIT_W];
                    push_type        = type_of(bus.in_flit_i, int'(grant_idx));
                end
            end
            LOCKED: begin
                ready[owner] = ~fifo_full;
                push         = bus.in_valid_i[owner] & ~fifo_full;
                push_flit    = bus.in_flit_i[int'(owner)*FLIT_W +: FLIT_W];
                push_type    = type_of(bus.in_flit_i, int'(owner));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            owner <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_multi) begin
                        err <= 1'b1;
                    end
                    if (accept_idle && push_type == HEAD) begin
                        state <= LOCKED;
                        owner <= grant_idx;
                    end
                end
                LOCKED: begin
                    // A stray head inside a packet is still forwarded; only flag it.
                    if (push) begin
                        if (push_type == TAIL) begin
                            state <= IDLE;
                        end else if (is_head(push_type)) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    noc_flit_fifo #(
        .FLIT_W    (FLIT_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (push),
        .push_flit (push_flit),
        .pop       (bus.out_ready_i),
        .head_flit (bus.out_flit_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.in_ready_o   = ready;
    assign bus.arb_req_o    = req;
    assign bus.arb_update_o = update;
    assign bus.out_valid_o  = ~fifo_empty;
    assign bus.busy_o       = (state == LOCKED);
    assign bus.err_o        = err;

endmodule

// File: doc/noc_output_port_ctrl.md
Name: noc_output_port_ctrl

Overview:
- Output-port controller for one router port. It sits between the per-input flit sources and the link, and wraps the two-requester round-robin arbiter (req/grant/update).
- Builds arbiter requests from pending head flits and consumes the one-hot grant.
- Holds the grant for a whole packet (wormhole lock) and pushes accepted flits into a small output FIFO that drives the link handshake.

Parameters:
- N_IN, 2, number of requesting inputs; must match the arbiter width.
- FLIT_W, 34, flit width: [33:32] flit type, [31:0] payload.
- BUF_DEPTH, 2, output FIFO depth; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  asynchronous active-low reset.
- in_valid_i  in  N_IN  per-input flit valid.
- in_flit_i  in  N_IN*FLIT_W  per-input flit; input k occupies bits [k*FLIT_W +: FLIT_W].
- in_ready_o  out  N_IN  per-input accept; a transfer occurs when valid & ready.
- arb_req_o  out  N_IN  request vector to the arbiter's req_i.
- arb_grant_i  in  N_IN  one-hot (or zero) grant from the arbiter's grant_o; combinational in the same cycle.
- arb_update_o  out  1  pulse to the arbiter's update_i; rotates its priority.
- out_valid_o  out  1  link flit valid.
- out_flit_o  out  FLIT_W  link flit.
- out_ready_i  in  1  link accept.
- busy_o  out  1  packet lock held (state LOCKED).
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset is asynchronous and active-low (arst_n); one clock (clk).
- Reset values:
  - State IDLE, owner 0, FIFO empty.
  - out_valid_o=0, out_flit_o=0, arb_req_o=0, arb_update_o=0, in_ready_o=0, busy_o=0, err_o=0.
- Flit type encoding: BODY=2'b00, HEAD=2'b01, TAIL=2'b10, HEAD_TAIL=2'b11.
- full = (count==BUF_DEPTH). Input acceptance never depends on out_ready_i in the same cycle (no bypass).
- IDLE:
  - arb_req_o[k] = in_valid_i[k] & type[k] in {HEAD, HEAD_TAIL} & !full.
  - If arb_grant_i has exactly one bit k set and arb_req_o[k]=1: in_ready_o[k]=1, the flit is pushed, and arb_update_o=1 in that same cycle.
  - Type HEAD: go to LOCKED and set owner=k. Type HEAD_TAIL: stay IDLE.
  - Grant zero, or grant on a non-requesting input: no transfer and no update.
  - Grant with more than one bit set: no transfer, no update, err_o set.
- LOCKED:
  - arb_req_o=0, arb_update_o=0.
  - in_ready_o[owner] = !full; all other in_ready_o bits are 0.
  - Accepted BODY flit: stay LOCKED. Accepted TAIL flit: return to IDLE on the next edge.
  - Accepted HEAD or HEAD_TAIL flit: forwarded unchanged, err_o set, state unchanged.
- FIFO:
  - out_valid_o = !empty; out_flit_o = entry at the read pointer (registered storage).
  - Pop on out_valid_o & out_ready_i.
  - Simultaneous push and pop: count unchanged, pointers wrap modulo BUF_DEPTH.
- Latency: a flit accepted at edge N is presented on out_flit_o after edge N, i.e. in cycle N+1 at the earliest.
- Fill limit: when the link stalls, at most BUF_DEPTH flits are accepted, then all in_ready_o drop.
- A packet lock survives any number of link stalls.
- Reset mid-packet: the lock and FIFO contents are discarded. Upstream sources must also be reset.
- err_o clears only on reset.

Decomposition:
- Package noc_pkg holds:
  - flit_type_t enum (BODY, HEAD, TAIL, HEAD_TAIL) and FLIT_W.
  - FLIT_TYPE_MSB/LSB constants.
  - Port-controller state enum {IDLE, LOCKED}.
- One sub-module: noc_flit_fifo (parameterised FLIT_W/BUF_DEPTH, push/pop/full/empty, async active-low reset).
- FSM, request generation and error detection stay in the top.
- The arbiter is instantiated by the parent, not inside this block.

Test Plan:
- Reset/idle:
  - Stimulus: arst_n low 3 cycles, then high with no valid inputs.
  - Response: all outputs 0; arb_req_o=2'b00 indefinitely.
- Single packet:
  - Stimulus: input 0 sends HEAD(0x11), BODY(0x22), TAIL(0x33); arbiter grant=2'b01; out_ready_i=1.
  - Response: arb_update_o pulses exactly once, on the HEAD cycle; busy_o=1 for 2 cycles.
  - Response: the link sees 0x11, 0x22, 0x33 on consecutive cycles starting one cycle after the HEAD.
- Lock holds against contention:
  - Stimulus: input 1 holds a valid HEAD throughout input 0's 4-flit packet.
  - Response: in_ready_o[1]=0 and arb_req_o=2'b00 until input 0's TAIL is accepted.
  - Response: the next cycle, arb_req_o[1]=1; grant 2'b10 transfers input 1's HEAD.
- Back-pressure:
  - Stimulus: out_ready_i=0 during a 5-flit packet.
  - Response: exactly 2 flits are accepted, then in_ready_o=0.
  - Stimulus: release out_ready_i.
  - Response: all 5 flits delivered in order, with no duplicate or lost flit.
- Single-flit packets:
  - Stimulus: back-to-back HEAD_TAIL flits alternating inputs, grant alternating 01/10.
  - Response: one flit per cycle, arb_update_o asserted every cycle, busy_o stays 0.
- Errors and mid-packet reset:
  - Stimulus: grant=2'b11 in IDLE.
  - Response: err_o=1, no transfer.
  - Stimulus: HEAD arrives mid-packet.
  - Response: the flit is forwarded and err_o=1.
  - Stimulus: arst_n pulsed low mid-packet.
  - Response: FIFO empty, state IDLE, err_o=0.
